// File: rtl/datapath_mc.sv
// datapath_mc: multi-register accumulator datapath.
// Holds NREG accumulators of WIDTH bits; each operation updates
// acc[SEL] <= acc[SEL] OPR B. Single-cycle ALU ops complete on the accept
// edge; SHL (n>0) and MUL iterate one bit per clock.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high; clears all state
//   start  - operation request, sampled only while idle
//   SEL    - target accumulator index, also read index for A
//   OPR    - operation code (ADD SUB AND OR XOR LOAD SHL MUL)
//   B      - second operand
//   A      - acc[SEL], combinational read
//   FLAGS  - {C,V,N,Z} of the last completed operation
//   busy   - high while a multi-cycle op is in progress
//   done   - one-cycle pulse, first cycle the new value is visible
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; single-cycle ops write back here
// S_SHIFT | shifting working reg left one bit per clock
// S_MULT  | radix-2 shift-add multiply, one multiplier bit per clock

module datapath_mc #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SELW  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [SELW-1:0]  SEL,
  input  logic [2:0]       OPR,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] A,
  output logic [3:0]       FLAGS,
  output logic             busy,
  output logic             done
);

  localparam int NW = $clog2(WIDTH);
  localparam int CW = NW + 1;
  localparam int M  = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MULT} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc [NREG];
  logic [3:0]         flags_q;
  logic               done_q;
  logic [SELW-1:0]    w_sel;
  logic [WIDTH-1:0]   w_val;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   a_cur;
  logic [NW-1:0]      shl_n;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   shift_nxt;
  logic               last;
  logic               one_cycle;

  logic               wr_en;
  logic [SELW-1:0]    wr_sel;
  logic [WIDTH-1:0]   wr_val;
  logic               wr_c;
  logic               wr_v;
  logic [3:0]         wr_flags;

  assign a_cur     = acc[SEL];
  assign A         = a_cur;
  assign FLAGS     = flags_q;
  assign done      = done_q;
  assign shl_n     = B[NW-1:0];
  assign sum_ext   = {1'b0, a_cur} + {1'b0, B};
  assign diff      = a_cur - B;
  assign last      = (count == CW'(1));
  assign shift_nxt = {w_val[M-1:0], 1'b0};
  // Low half of prod starts as the multiplier and is consumed LSB first;
  // the high half accumulates the partial product.
  assign mul_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, w_val} : '0);
  assign prod_nxt  = {mul_add, prod[WIDTH-1:1]};
  // SHL with n=0 is just a flag update on the unchanged value.
  assign one_cycle = (OPR != OP_MUL) && !((OPR == OP_SHL) && (shl_n != '0));
  assign wr_flags  = {wr_c, wr_v, wr_val[M], (wr_val == '0)};

  always_comb begin
    alu_res = a_cur;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OPR)
      OP_ADD: begin
        alu_res = sum_ext[M:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_cur[M] == B[M]) && (alu_res[M] != a_cur[M]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a_cur < B);
        alu_v   = (a_cur[M] != B[M]) && (alu_res[M] != a_cur[M]);
      end
      OP_AND:  alu_res = a_cur & B;
      OP_OR:   alu_res = a_cur | B;
      OP_XOR:  alu_res = a_cur ^ B;
      OP_LOAD: alu_res = B;
      default: alu_res = a_cur;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && !one_cycle) begin
          if (OPR == OP_MUL) state_nxt = S_MULT;
          else               state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: if (last) state_nxt = S_IDLE;
      S_MULT:  if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    wr_en  = 1'b0;
    wr_sel = SEL;
    wr_val = alu_res;
    wr_c   = alu_c;
    wr_v   = alu_v;
    case (state)
      S_IDLE: begin
        wr_en = start && one_cycle;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        wr_en  = last;
        wr_sel = w_sel;
        wr_val = shift_nxt;
        wr_c   = w_val[M];
        wr_v   = 1'b0;
      end
      S_MULT: begin
        busy   = 1'b1;
        wr_en  = last;
        wr_sel = w_sel;
        wr_val = prod_nxt[WIDTH-1:0];
        wr_c   = |prod_nxt[2*WIDTH-1:WIDTH];
        wr_v   = |prod_nxt[2*WIDTH-1:WIDTH];
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) acc[i] <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      w_sel   <= '0;
      w_val   <= '0;
      prod    <= '0;
      count   <= '0;
    end else begin
      done_q <= wr_en;
      if (wr_en) begin
        acc[wr_sel] <= wr_val;
        flags_q     <= wr_flags;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            w_sel <= SEL;
            w_val <= a_cur;
            prod  <= {{WIDTH{1'b0}}, B};
            count <= (OPR == OP_MUL) ? CW'(WIDTH) : {1'b0, shl_n};
          end
        end
        S_SHIFT: begin
          w_val <= shift_nxt;
          count <= count - CW'(1);
        end
        S_MULT: begin
          prod  <= prod_nxt;
          count <= count - CW'(1);
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
module tb_datapath_mc;
  localparam int WIDTH = 8;
  localparam int NREG  = 4;
  localparam int SELW  = 2;
  localparam int MOD   = 1 << WIDTH;

  localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, LOAD = 5, SHL = 6, MUL = 7;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [SELW-1:0]  SEL;
  logic [2:0]       OPR;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] A;
  logic [3:0]       FLAGS;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int m_acc [NREG];
  logic [3:0] m_flags;

  datapath_mc #(.WIDTH(WIDTH), .NREG(NREG), .SELW(SELW)) dut (
    .clock(clock), .reset(reset), .start(start), .SEL(SEL), .OPR(OPR),
    .B(B), .A(A), .FLAGS(FLAGS), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result, flags and latency in edges from plain arithmetic.
  task automatic model(input int op, input int a, input int b,
                       output int r, output logic [3:0] f, output int lat);
    int sa, sb, s, n;
    bit c, v;
    c = 0; v = 0; lat = 1; n = b % WIDTH; r = a;
    sa = (a >= MOD/2) ? a - MOD : a;
    sb = (b >= MOD/2) ? b - MOD : b;
    case (op)
      ADD: begin r = (a + b) % MOD; c = (a + b >= MOD); s = sa + sb; v = (s >= MOD/2) || (s < -MOD/2); end
      SUB: begin r = (a - b + MOD) % MOD; c = (a < b); s = sa - sb; v = (s >= MOD/2) || (s < -MOD/2); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      LOAD: r = b;
      SHL: begin
        r = (a << n) % MOD;
        c = (n > 0) ? (((a >> (WIDTH - n)) & 1) == 1) : 1'b0;
        lat = n + 1;
      end
      default: begin r = (a * b) % MOD; c = (a * b >= MOD); v = c; lat = WIDTH + 1; end
    endcase
    f = {c, v, (r >= MOD/2), (r == 0)};
  endtask

  task automatic run_op(input int sel, input int op, input int b);
    int r, lat, cyc;
    logic [3:0] f;
    model(op, m_acc[sel], b, r, f, lat);
    @(negedge clock);
    SEL = SELW'(sel); OPR = 3'(op); B = WIDTH'(b); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; OPR = 3'($urandom); B = WIDTH'($urandom);
    cyc = 1;
    while (!done && cyc < 3 * WIDTH) begin
      check("busy_during_op", busy, 1);
      SEL = SELW'($urandom); #1;
      check("a_old_during_busy", A, m_acc[SEL]);
      start = 1'($urandom_range(0, 1)); OPR = 3'($urandom); B = WIDTH'($urandom);
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, lat);
    check("done_at_completion", done, 1);
    check("busy_at_completion", busy, 0);
    m_acc[sel] = r; m_flags = f;
    SEL = SELW'(sel); #1;
    check("a_result", A, r);
    check("flags", FLAGS, f);
    @(posedge clock); #1;
    check("done_single_pulse", done, 0);
  endtask

  task automatic exp_reg(input string tag, input int sel, input logic [7:0] val, input logic [3:0] fl);
    @(negedge clock);
    SEL = SELW'(sel); #1;
    check(tag, A, val);
    check(tag, FLAGS, fl);
  endtask

  initial begin
    int r, lat;
    logic [3:0] f;
    bit seen;
    reset = 1'b1; start = 1'b0; SEL = '0; OPR = '0; B = '0;
    for (int i = 0; i < NREG; i++) m_acc[i] = 0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_flags", FLAGS, 0);
    for (int i = 0; i < NREG; i++) begin
      SEL = SELW'(i); #1;
      check("reset_acc", A, 0);
    end
    @(negedge clock); reset = 1'b0;

    run_op(0, ADD, 8'h05);
    run_op(0, ADD, 8'h05);
    exp_reg("plan_add_twice", 0, 8'h0A, 4'b0000);

    run_op(1, LOAD, 8'h7F);
    run_op(1, ADD, 8'h01);
    exp_reg("plan_add_overflow", 1, 8'h80, 4'b0110);
    run_op(1, SUB, 8'h80);
    exp_reg("plan_sub_zero", 1, 8'h00, 4'b0001);

    run_op(2, LOAD, 8'h81);
    run_op(2, SHL, 3);
    exp_reg("plan_shl3", 2, 8'h08, 4'b0000);
    run_op(2, LOAD, 8'hC1);
    run_op(2, SHL, 2);
    exp_reg("plan_shl2", 2, 8'h04, 4'b1000);
    run_op(2, SHL, 8);
    exp_reg("plan_shl0", 2, 8'h04, 4'b0000);

    run_op(3, LOAD, 20);
    run_op(3, MUL, 13);
    exp_reg("plan_mul", 3, 8'd4, 4'b1100);

    // Reset in the middle of a multiply.
    @(negedge clock);
    SEL = 2'd3; OPR = 3'(MUL); B = 8'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; #1;
    for (int i = 0; i < NREG; i++) m_acc[i] = 0;
    m_flags = 4'b0000;
    check("midop_reset_busy", busy, 0);
    check("midop_reset_done", done, 0);
    check("midop_reset_flags", FLAGS, 0);
    for (int i = 0; i < NREG; i++) begin
      SEL = SELW'(i); #1;
      check("midop_reset_acc", A, 0);
    end
    @(negedge clock); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1;
    end
    check("no_done_after_reset", seen, 0);
    SEL = 2'd3; #1;
    check("midop_acc3_clear", A, 0);
    run_op(3, ADD, 9);

    // Back-to-back ADD with start held for four cycles.
    @(negedge clock);
    SEL = 2'd0; OPR = 3'(ADD); B = 8'd1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      model(ADD, m_acc[0], 1, r, f, lat);
      m_acc[0] = r; m_flags = f;
      check("b2b_done", done, 1);
      check("b2b_busy", busy, 0);
      check("b2b_acc", A, r);
      check("b2b_flags", FLAGS, f);
    end
    start = 1'b0;
    @(posedge clock); #1;
    check("b2b_done_end", done, 0);
    check("b2b_final", A, 4);

    // Randomized operations against the model.
    repeat (80) begin
      run_op(int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)));
    end
    for (int i = 0; i < NREG; i++) begin
      @(negedge clock);
      SEL = SELW'(i); #1;
      check("final_acc", A, m_acc[i]);
    end
    check("final_flags", FLAGS, m_flags);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
